subtractor_serial: RTL and testbench

Bit-serial unsigned subtractor that computes `a - b` LSB-first over WIDTH cycles and returns a sign-carrying WIDTH+1-bit difference. It is the inverse-operation counterpart to the registered adder benchmark in the arithmetic generated-circuit set. It sits between a valid/ready producer and a valid/ready consumer, and trades throughput for a minimal single-bit datapath.

---
 rtl/subtractor_serial_if.sv | 23 ++
 rtl/subtractor_serial.sv | 90 +++++++++
 tb/tb_subtractor_serial.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/subtractor_serial_if.sv
// Valid/ready operand and result channels of the bit-serial subtractor.
// The master side produces operands and consumes results; the slave is the subtractor.
interface subtractor_serial_if #(
  parameter int WIDTH = 6
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   diff;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff
  );
endinterface

// File: rtl/subtractor_serial.sv
// Bit-serial unsigned subtractor: a - b computed LSB-first over WIDTH cycles,
// returned as a WIDTH+1-bit two's complement value {borrow, (a-b) mod 2^WIDTH}.
module subtractor_serial #(
  parameter int WIDTH = 6
) (
  input logic                clk,
  input logic                rst,
  subtractor_serial_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;

  logic w_a0;
  logic w_b0;
  logic w_d;
  logic w_borrow_nxt;
  logic w_accept;
  logic w_release;
  logic w_last;

  assign w_a0         = r_a_sh[0];
  assign w_b0         = r_b_sh[0];
  assign w_d          = w_a0 ^ w_b0 ^ r_borrow;
  assign w_borrow_nxt = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_release    = bus.out_valid & bus.out_ready;
  assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));

  // in_ready is gated by rst so an operand offered during reset is never taken.
  assign bus.in_ready  = (r_state == S_IDLE) & ~rst;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.diff      = {r_borrow, r_sh};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain borrow into the shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_sh     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_borrow <= w_borrow_nxt;
          r_sh     <= WIDTH'({w_d, r_sh} >> 1);
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          if (w_release) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: operand shifters carry no reset; they are always loaded on accept
  // before being consumed, so their contents after reset never reach diff.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_sh <= bus.a;
      r_b_sh <= bus.b;
    end else if (r_state == S_RUN) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
    end
  end

endmodule

// File: tb/tb_subtractor_serial.sv
// Self-checking bench for subtractor_serial: directed cases with literal results
// plus 1000 randomized operations against a cycle-level behavioural model.
module tb_subtractor_serial;

  localparam int W = 6;

  typedef logic [W:0] diff_t;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  subtractor_serial_if #(.WIDTH(W)) bus ();

  subtractor_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic diff_t ref_diff(input pair_t p);
    int d;
    d = int'(p.a) - int'(p.b);
    return diff_t'(d);
  endfunction

  // Behavioural model: one operation in flight, result visible W edges after accept.
  bit    m_on = 1'b0;
  bit    m_busy = 1'b0;
  int    m_elapsed = 0;
  pair_t m_cur;
  diff_t m_last = '0;
  int    n_acc = 0;
  int    n_dut_rel = 0;
  bit    exp_ov;

  always @(negedge clk) begin
    if (m_on) begin
      exp_ov = m_busy && (m_elapsed >= W);
      check("in_ready", bus.in_ready, !m_busy && !rst);
      check("out_valid", bus.out_valid, exp_ov);
      if (exp_ov) check("diff_done", bus.diff, ref_diff(m_cur));
      else if (!m_busy) check("diff_idle", bus.diff, m_last);
      if (!rst && bus.out_valid && bus.out_ready) n_dut_rel++;
    end
    if (rst === 1'b1) begin
      m_on      = 1'b1;
      m_busy    = 1'b0;
      m_last    = '0;
      n_acc     = 0;
      n_dut_rel = 0;
    end else if (m_on) begin
      if (!m_busy) begin
        if (bus.in_valid) begin
          m_busy    = 1'b1;
          m_elapsed = 0;
          m_cur     = '{a: bus.a, b: bus.b};
          n_acc++;
        end
      end else if (m_elapsed >= W) begin
        if (bus.out_ready) begin
          check("sign", bus.diff[W], m_cur.a < m_cur.b);
          m_last = ref_diff(m_cur);
          m_busy = 1'b0;
        end
      end else begin
        m_elapsed++;
      end
    end
  end

  // Present an operand pair and hold it until accepted; returns just after the accept edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    int t;
    t = 0;
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 200) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after accept until out_valid is seen; returns on that negedge.
  task automatic wait_result(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      lat++;
      if (lat > 200) begin
        check("result_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic directed(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input diff_t exp, input string nm);
    int lat;
    bus.out_ready = 1'b1;
    start_op(av, bv);
    wait_result(lat);
    check({nm, "_latency"}, lat, W);
    check(nm, bus.diff, exp);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({nm, "_ov_drop"}, bus.out_valid, 1'b0);
    check({nm, "_ready_back"}, bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  bit drv_done;

  initial begin
    int lat;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_diff", bus.diff, 7'h00);
    @(posedge clk);
    #1;

    directed(6'd45, 6'd17, 7'h1C, "basic");
    directed(6'd17, 6'd45, 7'h64, "negative");
    directed(6'd0,  6'd63, 7'h41, "zero_minus_max");
    directed(6'd63, 6'd0,  7'h3F, "max_minus_zero");
    directed(6'd42, 6'd42, 7'h00, "equal");
    directed(6'd0,  6'd0,  7'h00, "both_zero");

    // Backpressure: result held in DONE while a second operand waits.
    bus.out_ready = 1'b0;
    start_op(6'd45, 6'd17);
    wait_result(lat);
    check("bp_latency", lat, W);
    @(posedge clk);
    #1;
    bus.a        = 6'd1;
    bus.b        = 6'd2;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_ov", bus.out_valid, 1'b1);
      check("bp_hold_diff", bus.diff, 7'h1C);
      check("bp_hold_ready", bus.in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_release_ov", bus.out_valid, 1'b0);
    check("bp_release_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_result(lat);
    check("bp_second_latency", lat, W);
    check("bp_second_diff", bus.diff, 7'h7F);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // Reset in the third RUN cycle of 5 - 9.
    start_op(6'd5, 6'd9);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrun_ov", bus.out_valid, 1'b0);
    check("midrun_diff", bus.diff, 7'h00);
    check("midrun_ready_in_rst", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrun_ready_after", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    directed(6'd9, 6'd5, 7'h04, "after_reset");

    // Random back-to-back traffic with gaps and backpressure.
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          int gap;
          int t;
          gap = $urandom_range(0, 3);
          bus.in_valid = 1'b0;
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
          bus.a        = W'($urandom);
          bus.b        = W'($urandom);
          bus.in_valid = 1'b1;
          t = 0;
          forever begin
            @(negedge clk);
            if (bus.in_ready) begin
              @(posedge clk);
              #1;
              bus.in_valid = 1'b0;
              break;
            end
            @(posedge clk);
            #1;
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            t++;
            if (t > 500) begin
              check("rand_accept_timeout", 64'd0, 64'd1);
              bus.in_valid = 1'b0;
              break;
            end
          end
        end
        drv_done = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!(drv_done && !m_busy) && cyc < 60000) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
          cyc++;
        end
        if (cyc >= 60000) check("rand_drain_timeout", 64'd0, 64'd1);
      end
    join
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("release_count", n_dut_rel, n_acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
